// File: rtl/dsi_crc_pkg.sv
// Shared CRC-16 constants, FSM state type and the per-byte reflected update.
package dsi_crc_pkg;

    localparam logic [15:0] CRC16_POLY_REFL = 16'h8408;
    localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } crc_state_e;

    // Eight LSB-first steps of the reflected CRC over one byte.
    function automatic logic [15:0] crc16_byte(
        input logic [15:0] acc,
        input logic [7:0]  data,
        input logic [15:0] poly = CRC16_POLY_REFL
    );
        logic [15:0] a;
        logic        fb;
        a = acc;
        for (int i = 0; i < 8; i++) begin
            fb = a[0] ^ data[i];
            a  = (a >> 1) ^ (fb ? poly : 16'h0000);
        end
        return a;
    endfunction

endpackage

// File: rtl/dsi_crc16_lanes.sv
// Combinational LANES-wide chain of byte updates; only the first nbytes bytes
// (byte 0 first) fold into the accumulator.
module dsi_crc16_lanes
    import dsi_crc_pkg::*;
#(
    parameter int          LANES = 4,
    parameter logic [15:0] POLY  = CRC16_POLY_REFL
) (
    input  logic [15:0]                  acc_in,
    input  logic [8*LANES-1:0]           data,
    input  logic [$clog2(LANES+1)-1:0]   nbytes,
    output logic [15:0]                  acc_out
);

    // Ripple the accumulator through each enabled byte lane in wire order.
    always_comb begin
        acc_out = acc_in;
        for (int k = 0; k < LANES; k++) begin
            if (k < int'(nbytes)) begin
                acc_out = crc16_byte(acc_out, data[8*k +: 8], POLY);
            end
        end
    end

endmodule

// File: rtl/dsi_crc16_stream.sv
// Per-packet streaming CRC-16 for DSI long-packet payloads with a held,
// back-pressurable result and framing-error reporting.
module dsi_crc16_stream
    import dsi_crc_pkg::*;
#(
    parameter int          LANES = 4,
    parameter logic [15:0] POLY  = CRC16_POLY_REFL,
    parameter logic [15:0] INIT  = CRC16_INIT
) (
    input  logic                         dsi_clk,
    input  logic                         dsi_rst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [8*LANES-1:0]           s_data,
    input  logic                         s_sop,
    input  logic                         s_eop,
    input  logic [$clog2(LANES+1)-1:0]   s_bytes,
    output logic [15:0]                  crc,
    output logic                         crc_valid,
    input  logic                         crc_ready,
    output logic                         proto_err
);

    localparam int                CNT_W     = $clog2(LANES + 1);
    localparam logic [CNT_W-1:0]  LANES_CNT = CNT_W'(LANES);

    crc_state_e        state_q, state_d;
    logic [15:0]       acc_q, acc_d;
    logic [15:0]       crc_q, crc_d;
    logic              crc_valid_q, crc_valid_d;
    logic              proto_err_q, proto_err_d;

    logic              beat;
    logic              bytes_err;
    logic [CNT_W-1:0]  n_eff;
    logic [15:0]       seed;
    logic [15:0]       acc_upd;

    assign s_ready   = (state_q != DONE);
    assign crc       = crc_q;
    assign crc_valid = crc_valid_q;
    assign proto_err = proto_err_q;
    assign beat      = s_valid && s_ready;

    // Effective byte count: full beats except eop, oversize eop counts clamp.
    always_comb begin
        bytes_err = 1'b0;
        n_eff     = LANES_CNT;
        if (s_eop) begin
            if (s_bytes > LANES_CNT) begin
                bytes_err = 1'b1;
            end else begin
                n_eff = s_bytes;
            end
        end
        seed = ((state_q == IDLE) || s_sop) ? INIT : acc_q;
    end

    dsi_crc16_lanes #(
        .LANES (LANES),
        .POLY  (POLY)
    ) u_lanes (
        .acc_in  (seed),
        .data    (s_data),
        .nbytes  (n_eff),
        .acc_out (acc_upd)
    );

    // Next-state, accumulator and result/error register inputs.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        crc_d       = crc_q;
        crc_valid_d = crc_valid_q;
        proto_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (beat) begin
                    if (s_sop) begin
                        acc_d       = acc_upd;
                        proto_err_d = bytes_err;
                        state_d     = s_eop ? DONE : ACCUM;
                    end else begin
                        proto_err_d = 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (beat) begin
                    acc_d       = acc_upd;
                    proto_err_d = s_sop | bytes_err;
                    if (s_eop) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (crc_ready) begin
                    state_d     = IDLE;
                    acc_d       = INIT;
                    crc_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                acc_d       = INIT;
                crc_valid_d = 1'b0;
            end
        endcase
        if (state_d == DONE && state_q != DONE) begin
            crc_d       = acc_upd;
            crc_valid_d = 1'b1;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge dsi_clk or negedge dsi_rst_n) begin
        if (!dsi_rst_n) begin
            state_q     <= IDLE;
            acc_q       <= INIT;
            crc_q       <= 16'h0000;
            crc_valid_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            crc_q       <= crc_d;
            crc_valid_q <= crc_valid_d;
            proto_err_q <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_dsi_crc16_stream.sv
// Self-checking bench: directed vectors plus random packets on LANES=4 and
// LANES=1 instances, checked against a bit-serial reference model.
module tb_dsi_crc16_stream;

    typedef logic [7:0] bq_t[$];

    logic        dsi_clk = 1'b0;
    logic        dsi_rst_n = 1'b0;

    // LANES=4 instance signals
    logic        v4 = 0, sop4 = 0, eop4 = 0, rdy4_c = 0;
    logic [31:0] d4 = '0;
    logic [2:0]  sb4 = '0;
    logic        srdy4, cval4, perr4;
    logic [15:0] crc4;

    // LANES=1 instance signals
    logic        v1 = 0, sop1 = 0, eop1 = 0, rdy1_c = 0;
    logic [7:0]  d1 = '0;
    logic [0:0]  sb1 = '0;
    logic        srdy1, cval1, perr1;
    logic [15:0] crc1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 dsi_clk = ~dsi_clk;

    dsi_crc16_stream #(.LANES(4)) dut4 (
        .dsi_clk(dsi_clk), .dsi_rst_n(dsi_rst_n),
        .s_valid(v4), .s_ready(srdy4), .s_data(d4), .s_sop(sop4), .s_eop(eop4),
        .s_bytes(sb4), .crc(crc4), .crc_valid(cval4), .crc_ready(rdy4_c),
        .proto_err(perr4)
    );

    dsi_crc16_stream #(.LANES(1)) dut1 (
        .dsi_clk(dsi_clk), .dsi_rst_n(dsi_rst_n),
        .s_valid(v1), .s_ready(srdy1), .s_data(d1), .s_sop(sop1), .s_eop(eop1),
        .s_bytes(sb1), .crc(crc1), .crc_valid(cval1), .crc_ready(rdy1_c),
        .proto_err(perr1)
    );

    // Reference: the message as one LSB-first bit stream through the CRC register.
    function automatic logic [15:0] ref_crc(input bq_t msg);
        logic [15:0] r;
        logic        b;
        r = 16'hFFFF;
        for (int i = 0; i < msg.size() * 8; i++) begin
            b = msg[i / 8][i % 8];
            if (r[0] ^ b) r = (r >> 1) ^ 16'h8408;
            else          r = r >> 1;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // All tasks start and end at 1 time unit after a rising edge.
    task automatic send4(input logic [31:0] d, input logic sop, input logic eop, input logic [2:0] nb);
        int guard = 0;
        v4 = 1; d4 = d; sop4 = sop; eop4 = eop; sb4 = nb;
        while (!srdy4 && guard < 50) begin
            @(posedge dsi_clk); #1; guard++;
        end
        if (guard >= 50) chk("send4_timeout", {31'd0, srdy4}, 32'd1);
        @(posedge dsi_clk); #1;
        v4 = 0; sop4 = 0; eop4 = 0;
    endtask

    task automatic send1(input logic [7:0] d, input logic sop, input logic eop, input logic [0:0] nb);
        int guard = 0;
        v1 = 1; d1 = d; sop1 = sop; eop1 = eop; sb1 = nb;
        while (!srdy1 && guard < 50) begin
            @(posedge dsi_clk); #1; guard++;
        end
        if (guard >= 50) chk("send1_timeout", {31'd0, srdy1}, 32'd1);
        @(posedge dsi_clk); #1;
        v1 = 0; sop1 = 0; eop1 = 0;
    endtask

    task automatic send_pkt4(input bq_t msg);
        int          len;
        int          nb;
        logic [31:0] w;
        len = msg.size();
        if (len == 0) begin
            send4($urandom(), 1'b1, 1'b1, 3'd0);
        end else begin
            for (int i = 0; i < len; i += 4) begin
                nb = (len - i >= 4) ? 4 : len - i;
                w  = $urandom();
                for (int j = 0; j < nb; j++) w[8*j +: 8] = msg[i + j];
                if (i + 4 >= len) send4(w, i == 0, 1'b1, 3'(nb));
                else              send4(w, i == 0, 1'b0, 3'($urandom_range(0, 4)));
            end
        end
    endtask

    task automatic send_pkt1(input bq_t msg);
        int len;
        len = msg.size();
        if (len == 0) begin
            send1(8'($urandom()), 1'b1, 1'b1, 1'b0);
        end else begin
            for (int i = 0; i < len; i++) begin
                if (i == len - 1) send1(msg[i], i == 0, 1'b1, 1'b1);
                else              send1(msg[i], i == 0, 1'b0, 1'($urandom_range(0, 1)));
            end
        end
    endtask

    task automatic consume4(input int dly, input logic [15:0] exp);
        rdy4_c = 0;
        for (int k = 0; k < dly; k++) begin
            @(posedge dsi_clk); #1;
            chk("hold4_crc", {16'd0, crc4}, {16'd0, exp});
            chk("hold4_ready", {31'd0, srdy4}, 32'd0);
        end
        rdy4_c = 1;
        @(posedge dsi_clk); #1;
        rdy4_c = 0;
        chk("after_ack4_ready", {31'd0, srdy4}, 32'd1);
        chk("after_ack4_valid", {31'd0, cval4}, 32'd0);
    endtask

    task automatic consume1(input int dly, input logic [15:0] exp);
        rdy1_c = 0;
        for (int k = 0; k < dly; k++) begin
            @(posedge dsi_clk); #1;
            chk("hold1_crc", {16'd0, crc1}, {16'd0, exp});
        end
        rdy1_c = 1;
        @(posedge dsi_clk); #1;
        rdy1_c = 0;
        chk("after_ack1_ready", {31'd0, srdy1}, 32'd1);
    endtask

    task automatic expect4(input string tag, input logic [15:0] exp, input logic perr);
        chk({tag, "_valid"}, {31'd0, cval4}, 32'd1);
        chk({tag, "_crc"}, {16'd0, crc4}, {16'd0, exp});
        chk({tag, "_perr"}, {31'd0, perr4}, {31'd0, perr});
    endtask

    initial begin
        bq_t         m9;
        bq_t         m;
        logic [15:0] e;
        m9 = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

        // Reset values
        repeat (3) @(posedge dsi_clk);
        #1;
        chk("rst_crc4", {16'd0, crc4}, 32'd0);
        chk("rst_valid4", {31'd0, cval4}, 32'd0);
        chk("rst_perr4", {31'd0, perr4}, 32'd0);
        chk("rst_ready4", {31'd0, srdy4}, 32'd1);
        chk("rst_ready1", {31'd0, srdy1}, 32'd1);
        chk("ref_check_value", {16'd0, ref_crc(m9)}, 32'h6F91);
        @(negedge dsi_clk); dsi_rst_n = 1;
        @(posedge dsi_clk); #1;

        // "123456789" in three beats
        send4(32'h34333231, 1, 0, 3'd4);
        send4(32'h38373635, 0, 0, 3'd4);
        send4(32'h00000039, 0, 1, 3'd1);
        expect4("ascii", 16'h6F91, 1'b0);
        consume4(0, 16'h6F91);

        // Zero-length payload
        send4(32'hDEADBEEF, 1, 1, 3'd0);
        expect4("zero_len", 16'hFFFF, 1'b0);
        consume4(0, 16'hFFFF);

        // Back-pressure for five cycles
        send4(32'h34333231, 1, 0, 3'd4);
        send4(32'h38373635, 0, 0, 3'd4);
        send4(32'hA5A5A539, 0, 1, 3'd1);
        expect4("bp", 16'h6F91, 1'b0);
        consume4(5, 16'h6F91);

        // Framing errors: stray beat in IDLE, then sop restart mid-packet
        send4(32'h11223344, 0, 0, 3'd4);
        chk("stray_perr", {31'd0, perr4}, 32'd1);
        chk("stray_ready", {31'd0, srdy4}, 32'd1);
        send4(32'h34333231, 1, 0, 3'd4);
        chk("stray_perr_drop", {31'd0, perr4}, 32'd0);
        send4(32'h38373635, 0, 0, 3'd4);
        send4(32'h34333231, 1, 0, 3'd4);
        chk("restart_perr", {31'd0, perr4}, 32'd1);
        send4(32'h38373635, 0, 0, 3'd4);
        chk("restart_perr_drop", {31'd0, perr4}, 32'd0);
        send4(32'h00000039, 0, 1, 3'd1);
        expect4("restart", 16'h6F91, 1'b0);
        consume4(1, 16'h6F91);

        // Oversize byte count on eop clamps to four bytes
        m = {8'h31, 8'h32, 8'h33, 8'h34};
        send4(32'h34333231, 1, 1, 3'd6);
        expect4("oversize", ref_crc(m), 1'b1);
        consume4(0, ref_crc(m));

        // Reset between second and third beats
        send4(32'h34333231, 1, 0, 3'd4);
        send4(32'h38373635, 0, 0, 3'd4);
        dsi_rst_n = 0;
        #2;
        chk("midrst_valid", {31'd0, cval4}, 32'd0);
        chk("midrst_ready", {31'd0, srdy4}, 32'd1);
        @(negedge dsi_clk); dsi_rst_n = 1;
        @(posedge dsi_clk); #1;
        send4(32'h34333231, 1, 0, 3'd4);
        send4(32'h38373635, 0, 0, 3'd4);
        send4(32'h00000039, 0, 1, 3'd1);
        expect4("post_rst", 16'h6F91, 1'b0);
        consume4(0, 16'h6F91);

        // LANES=1 directed: nine single-byte beats
        send_pkt1(m9);
        chk("l1_valid", {31'd0, cval1}, 32'd1);
        chk("l1_crc", {16'd0, crc1}, 32'h6F91);
        chk("l1_perr", {31'd0, perr1}, 32'd0);
        consume1(2, 16'h6F91);

        // Random packets through both widths
        for (int p = 0; p < 24; p++) begin
            m.delete();
            for (int i = 0; i < int'($urandom_range(0, 19)); i++) m.push_back(8'($urandom()));
            e = ref_crc(m);
            send_pkt4(m);
            expect4("rand4", e, 1'b0);
            consume4(int'($urandom_range(0, 3)), e);
            send_pkt1(m);
            chk("rand1_valid", {31'd0, cval1}, 32'd1);
            chk("rand1_crc", {16'd0, crc1}, {16'd0, e});
            chk("rand1_perr", {31'd0, perr1}, 32'd0);
            consume1(int'($urandom_range(0, 2)), e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dsi_crc16_stream.md
# dsi_crc16_stream

Streaming CRC-16 checksum engine for DSI long-packet payloads, placed between the pixel-packing FIFO and the packet assembler. It consumes 1 to LANES bytes per clock over a valid/ready handshake with explicit start/end-of-packet markers. It delivers the 16-bit checksum, held until the consumer accepts it. It replaces the bit-serial, frame-sized checksum path with a width-parametrised, back-pressurable, per-packet engine that supports zero-length payloads.

## Interface
Parameters:
- LANES, 4: payload bytes per beat; legal values 1..4.
- POLY, 16'h8408: CRC polynomial in reflected form (x^16+x^12+x^5+1).
- INIT, 16'hFFFF: accumulator seed at start of each packet.

Ports:
- dsi_clk  input  1  single clock; everything is on its rising edge.
- dsi_rst_n  input  1  asynchronous, active-low reset.
- s_valid  input  1  input beat valid.
- s_ready  output  1  input beat accepted when s_valid && s_ready.
- s_data  input  8*LANES  payload; byte k is s_data[8k+7:8k]; byte 0 is first on the wire.
- s_sop  input  1  first beat of packet.
- s_eop  input  1  last beat of packet.
- s_bytes  input  $clog2(LANES+1)  count of valid bytes, low bytes first; sampled on eop beats only; all LANES bytes are valid on non-eop beats.
- crc  output  16  checksum result; stable while crc_valid.
- crc_valid  output  1  result available.
- crc_ready  input  1  consumer takes result when crc_valid && crc_ready.
- proto_err  output  1  one-cycle pulse on a framing violation.

## Operation
- FSM states:
  - IDLE: s_ready=1. An accepted beat with s_sop loads acc = update(INIT, beat).
    - If s_eop is also set, go to DONE; otherwise go to ACCUM.
    - An accepted beat without s_sop is dropped and pulses proto_err. State stays IDLE.
  - ACCUM: s_ready=1. An accepted beat updates acc = update(acc, beat).
    - If s_eop is set, go to DONE.
    - A beat with s_sop restarts: acc = update(INIT, beat) and proto_err pulses. The previous packet is discarded.
  - DONE: s_ready=0, crc_valid=1, crc=acc. On crc_ready, go to IDLE.
- update(): process bytes 0..n-1 in order. Each byte is processed LSB first, one bit per step:
  - fb = acc[0]^bit;
  - acc = (acc>>1) ^ (fb ? POLY : 0).
  - n = LANES on non-eop beats and s_bytes on eop beats.
- Zero-length payload: sop&&eop with s_bytes=0 gives crc=INIT (16'hFFFF).
- On an eop beat, s_bytes > LANES is treated as LANES and pulses proto_err.
- No final XOR. No output bit reversal. crc[7:0] is transmitted first.

## Timing
- Reset values:
  - state=IDLE, acc=INIT
  - crc=16'h0000, crc_valid=0, proto_err=0
  - s_ready=1 (decoded from state).
- The whole LANES-byte update is combinational and registered in one cycle, at full throughput of one beat per cycle.
- Latency: crc_valid rises the cycle after the eop beat is accepted.
- Back-to-back packets cost one bubble: s_ready is low for every DONE cycle, including the cycle in which crc_ready is sampled.
- crc and crc_valid are registered and hold indefinitely under crc_ready=0.
- proto_err is registered and rises the cycle after the offending beat.
- Reset asserted mid-packet or in DONE returns to IDLE immediately; the partial CRC is lost.

## Structure
- Shared package dsi_crc_pkg holds:
  - CRC16_POLY_REFL and CRC16_INIT constants;
  - a crc_state_e enum (IDLE, ACCUM, DONE);
  - a function crc16_byte(acc, byte) returning the 8-step update.
- One sub-module, dsi_crc16_lanes, is natural: a combinational LANES-wide chain of crc16_byte with a byte-count mask. The top holds the FSM and registers.

## Test plan
- LANES=4, ASCII "123456789": beats 32'h34333231 (sop), 32'h38373635, 32'h00000039 (eop, s_bytes=1) -> crc=16'h6F91 one cycle after the last accept.
- Single beat with sop&&eop and s_bytes=0 -> crc=16'hFFFF, crc_valid=1 next cycle, proto_err=0.
- Same vector as the first test with crc_ready held low for 5 cycles -> crc stays 16'h6F91, s_ready=0 throughout. After the crc_ready handshake, s_ready=1 the following cycle.
- Beat without sop in IDLE, then sop in ACCUM mid-packet -> one proto_err pulse for each. The restarted packet "123456789" still yields 16'h6F91.
- Reset asserted between the second and third beats of the first test -> crc_valid=0, s_ready=1. Resending the full packet yields 16'h6F91.
- LANES=1: the same nine bytes sent one per beat -> crc=16'h6F91. The result matches the LANES=4 run.
